// File: rtl/cell_hist_acc_pkg.sv
// ----------------------------------------------------------------------------
// cell_hist_acc_pkg
//   Shared definitions for the HOG cell histogram accumulator and the
//   orientation-bin calculator that feeds it.
//   Contents:
//     NUM_BINS              number of orientation bins (0,20,..,160 degrees)
//     BIN_*                 bin index of each orientation
//     MAG_I_DEF/MAG_F_DEF   default integer/fraction bits of a bin magnitude
//     acc_state_t           sync state of the accumulator
//     clog2_min1()          ceil(log2(n)) but never below 1, for port widths
// ----------------------------------------------------------------------------
package cell_hist_acc_pkg;

    localparam int NUM_BINS = 9;

    localparam int BIN_0   = 0;
    localparam int BIN_20  = 1;
    localparam int BIN_40  = 2;
    localparam int BIN_60  = 3;
    localparam int BIN_80  = 4;
    localparam int BIN_100 = 5;
    localparam int BIN_120 = 6;
    localparam int BIN_140 = 7;
    localparam int BIN_160 = 8;

    localparam int MAG_I_DEF = 9;
    localparam int MAG_F_DEF = 16;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_ACCUM    = 1'b1
    } acc_state_t;

    // A cell grid one cell tall still needs a 1-bit row index on the port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cell_hist_cnt.sv
// ----------------------------------------------------------------------------
// cell_hist_cnt
//   Raster position tracker for the cell histogram accumulator. Holds the
//   position of the next pixel (px_x, line within the cell row, cell_y) and
//   decodes the cell coordinates and completion flags of the current pixel.
//   Ports:
//     clk, rst     clock, async active-high reset
//     adv          current pixel is accepted; counters step past it
//     restart      current pixel is a frame start; it is treated as (0,0)
//     cx, cy       cell column / cell row of the current pixel
//     cell_done    current accepted pixel is the last pixel of its cell
//     frame_done   current accepted pixel is the last pixel of the frame
// ----------------------------------------------------------------------------
module cell_hist_cnt
    import cell_hist_acc_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CELL_SZ = 8
)(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    adv,
    input  logic                                    restart,
    output logic [clog2_min1(IMG_W/CELL_SZ)-1:0]    cx,
    output logic [clog2_min1(IMG_H/CELL_SZ)-1:0]    cy,
    output logic                                    cell_done,
    output logic                                    frame_done
);

    localparam int NUM_CY   = IMG_H / CELL_SZ;
    localparam int X_W      = clog2_min1(IMG_W);
    localparam int L_W      = clog2_min1(CELL_SZ);
    localparam int CX_W     = clog2_min1(IMG_W / CELL_SZ);
    localparam int CY_W     = clog2_min1(NUM_CY);
    localparam int LOG_CELL = $clog2(CELL_SZ);

    logic [X_W-1:0]  px_x,   cur_x;
    logic [L_W-1:0]  line,   cur_line;
    logic [CY_W-1:0] cell_y, cur_cy;
    logic            last_x, last_col_in_cell, last_line, last_cy;

    // A frame start overrides the stored position: the pixel carrying in_sof
    // is (0,0) no matter where the previous frame was abandoned.
    always_comb begin
        cur_x    = restart ? '0 : px_x;
        cur_line = restart ? '0 : line;
        cur_cy   = restart ? '0 : cell_y;

        last_x           = (cur_x == X_W'(IMG_W - 1));
        last_col_in_cell = ((cur_x & X_W'(CELL_SZ - 1)) == X_W'(CELL_SZ - 1));
        last_line        = (cur_line == L_W'(CELL_SZ - 1));
        last_cy          = (cur_cy == CY_W'(NUM_CY - 1));

        cx         = CX_W'(cur_x >> LOG_CELL);
        cy         = cur_cy;
        cell_done  = adv & last_col_in_cell & last_line;
        frame_done = cell_done & last_x & last_cy;
    end

    // All three counters wrap together on the last pixel, so the block is
    // already at (0,0) when the next frame's sof arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_x   <= '0;
            line   <= '0;
            cell_y <= '0;
        end else if (adv) begin
            px_x <= last_x ? '0 : cur_x + X_W'(1);

            if (last_x)
                line <= last_line ? '0 : cur_line + L_W'(1);
            else
                line <= cur_line;

            if (last_x && last_line)
                cell_y <= last_cy ? '0 : cur_cy + CY_W'(1);
            else
                cell_y <= cur_cy;
        end
    end

endmodule

// File: rtl/cell_hist_acc.sv
// ----------------------------------------------------------------------------
// cell_hist_acc
//   Accumulates per-pixel orientation-bin magnitudes into 9-bin HOG
//   histograms over CELL_SZ x CELL_SZ cells. Pixels arrive in raster order;
//   one row of partial histograms (one per cell column) is kept in registers
//   and a cell's histogram is emitted the cycle after its last pixel.
//   Ports:
//     clk, rst     clock, async active-high reset
//     in_valid     pixel bins valid this cycle (no backpressure)
//     in_sof       first pixel of a frame, qualified by in_valid
//     in_bins      bin k at [k*MAG_W +: MAG_W], unsigned fixed point
//     out_valid    one-cycle pulse, out_hist valid
//     out_cell_x   cell column of out_hist
//     out_cell_y   cell row of out_hist
//     out_hist     bin k at [k*SUM_W +: SUM_W], unsigned
//     out_eof      with out_valid, last cell of the frame
// ----------------------------------------------------------------------------
module cell_hist_acc
    import cell_hist_acc_pkg::*;
#(
    parameter int  MAG_I   = MAG_I_DEF,
    parameter int  MAG_F   = MAG_F_DEF,
    parameter int  IMG_W   = 640,
    parameter int  IMG_H   = 480,
    parameter int  CELL_SZ = 8,
    localparam int MAG_W   = MAG_I + MAG_F,
    localparam int SUM_W   = MAG_W + 2 * $clog2(CELL_SZ),
    localparam int NUM_CX  = IMG_W / CELL_SZ,
    localparam int CX_W    = clog2_min1(NUM_CX),
    localparam int CY_W    = clog2_min1(IMG_H / CELL_SZ)
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [NUM_BINS*MAG_W-1:0]   in_bins,
    output logic                        out_valid,
    output logic [CX_W-1:0]             out_cell_x,
    output logic [CY_W-1:0]             out_cell_y,
    output logic [NUM_BINS*SUM_W-1:0]   out_hist,
    output logic                        out_eof
);

    acc_state_t state, state_next;

    logic            synced;
    logic            accept;
    logic            restart;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            cell_done;
    logic            frame_done;

    logic [SUM_W-1:0]          acc [NUM_CX][NUM_BINS];
    logic [SUM_W-1:0]          sum [NUM_BINS];
    logic [NUM_BINS*SUM_W-1:0] sum_flat;

    // ------------------------------------------------------------------
    // Sync FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_WAIT_SOF;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT_SOF: if (restart && !frame_done) state_next = ST_ACCUM;
            ST_ACCUM:    if (frame_done)             state_next = ST_WAIT_SOF;
            default:                                 state_next = ST_WAIT_SOF;
        endcase
    end

    // Pixels before the first sof are dropped; a sof pixel is always taken.
    always_comb begin
        synced  = (state == ST_ACCUM);
        restart = in_valid & in_sof;
        accept  = in_valid & (in_sof | synced);
    end

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    cell_hist_cnt #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .CELL_SZ (CELL_SZ)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .adv        (accept),
        .restart    (restart),
        .cx         (cx),
        .cy         (cy),
        .cell_done  (cell_done),
        .frame_done (frame_done)
    );

    // ------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------
    // On a restart the old partial sum of column 0 belongs to the abandoned
    // frame, so the new pixel is added to zero instead.
    always_comb begin
        sum_flat = '0;
        for (int k = 0; k < NUM_BINS; k++) begin
            sum[k] = (restart ? '0 : acc[cx][k]) + SUM_W'(in_bins[k*MAG_W +: MAG_W]);
            sum_flat[k*SUM_W +: SUM_W] = sum[k];
        end
    end

    // The completing pixel clears its column instead of storing the sum,
    // so the same column starts fresh for the next cell row.
    // NOTE: the accumulator array is reset because a cell's first pixel is
    // added to whatever the entry holds; unreset entries would corrupt the
    // first histograms after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CX; c++)
                for (int k = 0; k < NUM_BINS; k++)
                    acc[c][k] <= '0;
        end else if (accept) begin
            for (int c = 0; c < NUM_CX; c++)
                for (int k = 0; k < NUM_BINS; k++)
                    if (CX_W'(c) == cx)
                        acc[c][k] <= cell_done ? '0 : sum[k];
                    else if (restart)
                        acc[c][k] <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_eof    <= 1'b0;
            out_hist   <= '0;
            out_cell_x <= '0;
            out_cell_y <= '0;
        end else begin
            out_valid <= cell_done;
            out_eof   <= frame_done;
            if (cell_done) begin
                out_hist   <= sum_flat;
                out_cell_x <= cx;
                out_cell_y <= cy;
            end
        end
    end

endmodule

// File: tb/tb_cell_hist_acc.sv
// ----------------------------------------------------------------------------
// tb_cell_hist_acc
//   Self-checking bench for cell_hist_acc on a 16x8 image with 8x8 cells.
//   Each frame is described as a per-pixel (bin, magnitude) table; expected
//   histograms are sums over each cell's pixels of that table.
// ----------------------------------------------------------------------------
module tb_cell_hist_acc;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 8;
    localparam int CELL_SZ = 8;
    localparam int MAG_W   = 25;
    localparam int SUM_W   = 31;
    localparam int NB      = 9;
    localparam int NCX     = IMG_W / CELL_SZ;
    localparam int NCY     = IMG_H / CELL_SZ;
    localparam int NPIX    = IMG_W * IMG_H;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_sof;
    logic [NB*MAG_W-1:0]   in_bins;
    logic                  out_valid;
    logic [0:0]            out_cell_x;
    logic [0:0]            out_cell_y;
    logic [NB*SUM_W-1:0]   out_hist;
    logic                  out_eof;

    int errors = 0;
    int checks = 0;

    int               pix_k [IMG_H][IMG_W];
    logic [MAG_W-1:0] pix_m [IMG_H][IMG_W];

    typedef struct {
        int                  cx;
        int                  cy;
        logic                eof;
        logic [NB*SUM_W-1:0] hist;
    } out_t;

    out_t got_q[$];

    cell_hist_acc #(
        .MAG_I   (9),
        .MAG_F   (16),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .CELL_SZ (CELL_SZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_bins    (in_bins),
        .out_valid  (out_valid),
        .out_cell_x (out_cell_x),
        .out_cell_y (out_cell_y),
        .out_hist   (out_hist),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1)
            got_q.push_back('{cx: int'(out_cell_x), cy: int'(out_cell_y),
                              eof: out_eof, hist: out_hist});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [NB*MAG_W-1:0] pack_pixel(input int k, input logic [MAG_W-1:0] m);
        logic [NB*MAG_W-1:0] v;
        v = '0;
        v[k*MAG_W +: MAG_W] = m;
        return v;
    endfunction

    function automatic logic [NB*MAG_W-1:0] rand_bins();
        logic [NB*MAG_W-1:0] v;
        for (int b = 0; b < NB*MAG_W; b++) v[b] = 1'($urandom_range(1));
        return v;
    endfunction

    // One clock with the given inputs; afterwards out_valid must show
    // whether that cycle's pixel completed a cell.
    task automatic drive_cycle(input logic v, input logic s, input logic [NB*MAG_W-1:0] b,
                               input logic exp_ov, input string tag);
        in_valid = v;
        in_sof   = s;
        in_bins  = b;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== exp_ov) begin
            errors++;
            $display("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_ov);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'($urandom_range(1)), rand_bins(), 1'b0, "idle");
    endtask

    // Raster pixels first..last of the current table; pixel 0 carries sof.
    task automatic drive_pixels(input int first, input int last, input int gap_pct);
        for (int idx = first; idx <= last; idx++) begin
            int x, y;
            x = idx % IMG_W;
            y = idx / IMG_W;
            while ($urandom_range(99) < gap_pct)
                drive_cycle(1'b0, 1'($urandom_range(1)), rand_bins(), 1'b0, "gap");
            drive_cycle(1'b1, (idx == 0), pack_pixel(pix_k[y][x], pix_m[y][x]),
                        ((x % CELL_SZ) == CELL_SZ-1) && ((y % CELL_SZ) == CELL_SZ-1), "pixel");
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic fill_random();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                pix_k[y][x] = $urandom_range(NB-1);
                pix_m[y][x] = MAG_W'($urandom);
            end
    endtask

    // Reference: every cell's histogram is the plain sum of its pixels'
    // magnitudes into their bins; cells emerge row by row, left to right.
    task automatic compare_frame(input string tag);
        checks++;
        if (got_q.size() !== NCX*NCY) begin
            errors++;
            $display("FAIL %s output count: got %0d want %0d", tag, got_q.size(), NCX*NCY);
        end
        for (int cy = 0; cy < NCY; cy++)
            for (int cx = 0; cx < NCX; cx++) begin
                int                  idx;
                longint              e [NB];
                out_t                g;
                logic [NB*SUM_W-1:0] h;
                idx = cy*NCX + cx;
                for (int k = 0; k < NB; k++) e[k] = 0;
                for (int y = cy*CELL_SZ; y < (cy+1)*CELL_SZ; y++)
                    for (int x = cx*CELL_SZ; x < (cx+1)*CELL_SZ; x++)
                        e[pix_k[y][x]] += longint'(pix_m[y][x]);
                if (idx < got_q.size()) begin
                    g = got_q[idx];
                    h = g.hist;
                    checks++;
                    if (g.cx !== cx || g.cy !== cy) begin
                        errors++;
                        $display("FAIL %s cell%0d coords: got (%0d,%0d) want (%0d,%0d)",
                                 tag, idx, g.cx, g.cy, cx, cy);
                    end
                    checks++;
                    if (g.eof !== (idx == NCX*NCY-1)) begin
                        errors++;
                        $display("FAIL %s cell%0d eof: got %b want %b", tag, idx, g.eof, idx == NCX*NCY-1);
                    end
                    for (int k = 0; k < NB; k++) begin
                        checks++;
                        if (h[k*SUM_W +: SUM_W] !== SUM_W'(e[k])) begin
                            errors++;
                            $display("FAIL %s cell%0d bin%0d: got %h want %h",
                                     tag, idx, k, h[k*SUM_W +: SUM_W], SUM_W'(e[k]));
                        end
                    end
                end
            end
        got_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bins  = '0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got valid=%b eof=%b want 0 0", out_valid, out_eof);
        end
        checks++;
        if (out_hist !== '0) begin
            errors++;
            $display("FAIL reset hist: got %h want 0", out_hist);
        end
        checks++;
        if (out_cell_x !== 1'b0 || out_cell_y !== 1'b0) begin
            errors++;
            $display("FAIL reset cell: got (%b,%b) want (0,0)", out_cell_x, out_cell_y);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        got_q.delete();
    endtask

    task automatic test_single_cell();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                pix_k[y][x] = 0;
                pix_m[y][x] = (x < CELL_SZ) ? 25'h10000 : 25'h0;
            end
        drive_pixels(0, 7*IMG_W + 7, 0);
        // Right after the edge that accepted pixel (7,7).
        checks++;
        if (out_hist[0 +: SUM_W] !== 31'h400000) begin
            errors++;
            $display("FAIL single bin0: got %h want 0400000", out_hist[0 +: SUM_W]);
        end
        checks++;
        if (out_hist[NB*SUM_W-1:SUM_W] !== '0) begin
            errors++;
            $display("FAIL single other bins: got %h want 0", out_hist[NB*SUM_W-1:SUM_W]);
        end
        checks++;
        if (out_cell_x !== 1'b0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL single cell/eof: got x=%b eof=%b want 0 0", out_cell_x, out_eof);
        end
        drive_pixels(7*IMG_W + 8, NPIX-1, 0);
        idle(2);
        compare_frame("single");
    endtask

    task automatic test_rotate();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                pix_k[y][x] = (x + y) % NB;
                pix_m[y][x] = 25'h10000;
            end
        drive_pixels(0, NPIX-1, 0);
        idle(2);
        compare_frame("rotate");
    endtask

    task automatic test_max();
        logic [NB*SUM_W-1:0] first_hist;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                pix_k[y][x] = 8;
                pix_m[y][x] = 25'h1FFFFFF;
            end
        drive_pixels(0, NPIX-1, 0);
        idle(2);
        first_hist = (got_q.size() > 0) ? got_q[0].hist : '0;
        compare_frame("max1");
        drive_pixels(0, NPIX-1, 0);
        idle(2);
        checks++;
        if (got_q.size() == 0 || got_q[0].hist !== first_hist) begin
            errors++;
            $display("FAIL max repeat: second frame cell0 differs from first (%0d outputs)", got_q.size());
        end
        compare_frame("max2");
    endtask

    task automatic test_gaps();
        fill_random();
        for (int i = 0; i < 20; i++)
            drive_cycle(1'b1, 1'b0, rand_bins(), 1'b0, "presof");
        drive_pixels(0, NPIX-1, 50);
        idle(2);
        compare_frame("gaps");
    endtask

    task automatic test_mid_sof();
        fill_random();
        drive_pixels(0, 3*IMG_W + 4, 0);
        fill_random();
        drive_pixels(0, NPIX-1, 0);
        idle(2);
        compare_frame("midsof");
    endtask

    task automatic test_rst_mid();
        fill_random();
        drive_pixels(0, 7*IMG_W + 7, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_eof !== 1'b0 || out_hist !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got valid=%b eof=%b hist=%h want all 0",
                     out_valid, out_eof, out_hist);
        end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        idle(1);
        fill_random();
        drive_pixels(0, NPIX-1, 0);
        idle(2);
        compare_frame("rst_mid");
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_rotate();
        test_max();
        test_gaps();
        test_mid_sof();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
